// File: rtl/commit_sequencer.sv
// In-order commit controller: circular ROB that allocates ids, captures CDB results,
// retires the head entry to the register file and flushes on a mispredicted branch.
module commit_sequencer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 allocFlag,
  input  logic                 allocHasRd,
  input  logic [4:0]           allocRd,
  input  logic                 allocIsBranch,
  output logic [ROB_WIDTH-1:0] allocId,
  output logic                 full,
  input  logic                 cdbFlag,
  input  logic [ROB_WIDTH-1:0] cdbId,
  input  logic [31:0]          cdbValue,
  input  logic                 cdbMispredict,
  input  logic [ROB_WIDTH-1:0] query1Id,
  output logic                 query1Ready,
  output logic [31:0]          query1Value,
  input  logic [ROB_WIDTH-1:0] query2Id,
  output logic                 query2Ready,
  output logic [31:0]          query2Value,
  output logic                 writeFlag,
  output logic [ROB_WIDTH-1:0] robId,
  output logic [4:0]           writeAddr,
  output logic [31:0]          writeValue,
  output logic                 clearOut
);

  localparam int ROB_SIZE = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(ROB_SIZE);

  typedef logic [ROB_WIDTH-1:0] id_t;

  logic [ROB_SIZE-1:0] valid_q, valid_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [ROB_SIZE-1:0] branch_q, mispred_q;
  logic [4:0]          rd_q    [ROB_SIZE];
  logic [31:0]         value_q [ROB_SIZE];

  id_t                 head_q, head_d;
  id_t                 tail_q, tail_d;
  logic [ROB_WIDTH:0]  count_q, count_d;

  logic                write_flag_q, write_flag_d;
  id_t                 rob_id_q, rob_id_d;
  logic [4:0]          write_addr_q, write_addr_d;
  logic [31:0]         write_value_q, write_value_d;
  logic                clear_q, clear_d;

  logic empty, do_alloc, do_cdb, do_commit, do_flush;

  assign empty     = (count_q == '0);
  assign full      = !clear_q && (count_q == FULL_COUNT);
  assign allocId   = clear_q ? '0 : tail_q;

  // full is taken from the pre-commit count, so a retiring slot is not reusable this cycle.
  assign do_alloc  = readyIn && allocFlag && !full && !clear_q;
  assign do_cdb    = readyIn && cdbFlag && valid_q[cdbId];
  assign do_commit = readyIn && !empty && valid_q[head_q] && ready_q[head_q];
  assign do_flush  = do_commit && branch_q[head_q] && mispred_q[head_q];

  assign query1Ready = (cdbFlag && (cdbId == query1Id)) || (valid_q[query1Id] && ready_q[query1Id]);
  assign query1Value = (cdbFlag && (cdbId == query1Id)) ? cdbValue : value_q[query1Id];
  assign query2Ready = (cdbFlag && (cdbId == query2Id)) || (valid_q[query2Id] && ready_q[query2Id]);
  assign query2Value = (cdbFlag && (cdbId == query2Id)) ? cdbValue : value_q[query2Id];

  assign writeFlag  = write_flag_q;
  assign robId      = rob_id_q;
  assign writeAddr  = write_addr_q;
  assign writeValue = write_value_q;
  assign clearOut   = clear_q;

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    valid_d       = valid_q;
    ready_d       = ready_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    write_flag_d  = write_flag_q;
    rob_id_d      = rob_id_q;
    write_addr_d  = write_addr_q;
    write_value_d = write_value_q;
    clear_d       = clear_q;

    if (readyIn) begin
      write_flag_d = 1'b0;
      clear_d      = 1'b0;
    end

    if (do_cdb) begin
      ready_d[cdbId] = 1'b1;
    end

    if (do_commit) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
      rob_id_d        = head_q;
      write_addr_d    = rd_q[head_q];
      write_value_d   = value_q[head_q];
      write_flag_d    = !branch_q[head_q] && (rd_q[head_q] != 5'd0);
    end

    // Alloc is applied after the CDB update so it wins on a shared index.
    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + 1'b1;
    end

    count_d = count_q + {{ROB_WIDTH{1'b0}}, do_alloc} - {{ROB_WIDTH{1'b0}}, do_commit};

    if (do_flush) begin
      valid_d      = '0;
      ready_d      = '0;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      clear_d      = 1'b1;
      write_flag_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      valid_q       <= '0;
      ready_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      write_flag_q  <= 1'b0;
      rob_id_q      <= '0;
      write_addr_q  <= '0;
      write_value_q <= '0;
      clear_q       <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      write_flag_q  <= write_flag_d;
      rob_id_q      <= rob_id_d;
      write_addr_q  <= write_addr_d;
      write_value_q <= write_value_d;
      clear_q       <= clear_d;
    end
  end

  // NOTE: payload storage is not reset; it is only observed once valid/ready say it was written.
  always_ff @(posedge clockIn) begin
    if (do_cdb) begin
      value_q[cdbId]   <= cdbValue;
      mispred_q[cdbId] <= cdbMispredict;
    end
    if (do_alloc) begin
      rd_q[tail_q]      <= allocHasRd ? allocRd : 5'd0;
      branch_q[tail_q]  <= allocIsBranch;
      mispred_q[tail_q] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_commit_sequencer.sv
// Directed bench for commit_sequencer: vector table for the main flow, hand sequences for
// full/wrap, mispredict flush and mid-operation reset.
module tb_commit_sequencer;

  logic        clk = 1'b0;
  logic        resetIn, readyIn;
  logic        allocFlag, allocHasRd, allocIsBranch;
  logic [4:0]  allocRd;
  logic [3:0]  allocId;
  logic        full;
  logic        cdbFlag, cdbMispredict;
  logic [3:0]  cdbId;
  logic [31:0] cdbValue;
  logic [3:0]  query1Id, query2Id;
  logic        query1Ready, query2Ready;
  logic [31:0] query1Value, query2Value;
  logic        writeFlag, clearOut;
  logic [3:0]  robId;
  logic [4:0]  writeAddr;
  logic [31:0] writeValue;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  commit_sequencer #(.ROB_WIDTH(4)) dut (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn),
    .allocFlag(allocFlag), .allocHasRd(allocHasRd), .allocRd(allocRd),
    .allocIsBranch(allocIsBranch), .allocId(allocId), .full(full),
    .cdbFlag(cdbFlag), .cdbId(cdbId), .cdbValue(cdbValue), .cdbMispredict(cdbMispredict),
    .query1Id(query1Id), .query1Ready(query1Ready), .query1Value(query1Value),
    .query2Id(query2Id), .query2Ready(query2Ready), .query2Value(query2Value),
    .writeFlag(writeFlag), .robId(robId), .writeAddr(writeAddr),
    .writeValue(writeValue), .clearOut(clearOut)
  );

  typedef struct {
    logic        rdy;
    logic        alloc;
    logic        has_rd;
    logic [4:0]  rd;
    logic        cdb;
    logic [3:0]  cid;
    logic [31:0] cval;
    logic        q_chk;
    logic [3:0]  qid;
    logic        q_rdy;
    logic [31:0] q_val;
    logic [3:0]  e_aid;
    logic        e_wf;
    logic [3:0]  e_rid;
    logic [4:0]  e_addr;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    readyIn = 1'b1; allocFlag = 1'b0; allocHasRd = 1'b0; allocRd = '0; allocIsBranch = 1'b0;
    cdbFlag = 1'b0; cdbId = '0; cdbValue = '0; cdbMispredict = 1'b0;
    query1Id = '0; query2Id = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetIn = 1'b1;
    step();
    step();
    resetIn = 1'b0;
  endtask

  task automatic alloc_in(input logic [4:0] rd, input logic has_rd, input logic br);
    allocFlag = 1'b1; allocRd = rd; allocHasRd = has_rd; allocIsBranch = br;
  endtask

  task automatic cdb_in(input logic [3:0] id, input logic [31:0] val, input logic mp);
    cdbFlag = 1'b1; cdbId = id; cdbValue = val; cdbMispredict = mp;
  endtask

  function automatic vec_t mk(input logic rdy, input logic alloc, input logic has_rd,
                              input logic [4:0] rd, input logic cdb, input logic [3:0] cid,
                              input logic [31:0] cval, input logic q_chk, input logic [3:0] qid,
                              input logic q_rdy, input logic [31:0] q_val, input logic [3:0] e_aid,
                              input logic e_wf, input logic [3:0] e_rid, input logic [4:0] e_addr,
                              input logic [31:0] e_val);
    vec_t v;
    v.rdy = rdy; v.alloc = alloc; v.has_rd = has_rd; v.rd = rd;
    v.cdb = cdb; v.cid = cid; v.cval = cval;
    v.q_chk = q_chk; v.qid = qid; v.q_rdy = q_rdy; v.q_val = q_val;
    v.e_aid = e_aid; v.e_wf = e_wf; v.e_rid = e_rid; v.e_addr = e_addr; v.e_val = e_val;
    return v;
  endfunction

  initial begin
    // Main flow: single commit with 2-cycle latency, out-of-order completion, forwarding,
    // rd=0 commit, readyIn stall holding outputs.
    //            rdy al hr rd  cdb id cval        qc qid qr qval        aid wf rid addr val
    vecs.push_back(mk(1, 1, 1, 5, 0, 0, 0,          0, 0, 0, 0,          0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 32'h1234,   0, 0, 0, 0,          1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          1, 1, 0, 5, 32'h1234));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          1, 0, 0, 5, 32'h1234));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0,          0, 0, 0, 0,          1, 0, 0, 5, 32'h1234));
    vecs.push_back(mk(1, 1, 1, 2, 0, 0, 0,          0, 0, 0, 0,          2, 0, 0, 5, 32'h1234));
    vecs.push_back(mk(1, 1, 1, 3, 0, 0, 0,          0, 0, 0, 0,          3, 0, 0, 5, 32'h1234));
    vecs.push_back(mk(1, 0, 0, 0, 1, 3, 32'h33,     0, 0, 0, 0,          4, 0, 0, 5, 32'h1234));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2, 32'h22,     0, 0, 0, 0,          4, 0, 0, 5, 32'h1234));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 32'h11,     1, 1, 1, 32'h11,     4, 0, 0, 5, 32'h1234));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          4, 1, 1, 1, 32'h11));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          4, 1, 2, 2, 32'h22));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          4, 1, 3, 3, 32'h33));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          4, 0, 3, 3, 32'h33));
    vecs.push_back(mk(1, 1, 0, 9, 0, 0, 0,          1, 4, 0, 0,          4, 0, 3, 3, 32'h33));
    vecs.push_back(mk(1, 0, 0, 0, 1, 4, 32'hBEEF,   1, 4, 1, 32'hBEEF,   5, 0, 3, 3, 32'h33));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          1, 4, 1, 32'hBEEF,   5, 0, 4, 0, 32'hBEEF));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          5, 0, 4, 0, 32'hBEEF));
    vecs.push_back(mk(1, 1, 1, 6, 0, 0, 0,          0, 0, 0, 0,          5, 0, 4, 0, 32'hBEEF));
    vecs.push_back(mk(1, 1, 1, 7, 0, 0, 0,          0, 0, 0, 0,          6, 0, 4, 0, 32'hBEEF));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, 32'h66,     0, 0, 0, 0,          7, 0, 4, 0, 32'hBEEF));
    vecs.push_back(mk(1, 0, 0, 0, 1, 6, 32'h77,     0, 0, 0, 0,          7, 1, 5, 6, 32'h66));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          7, 1, 5, 6, 32'h66));
    vecs.push_back(mk(0, 1, 1, 9, 0, 0, 0,          0, 0, 0, 0,          7, 1, 5, 6, 32'h66));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          7, 1, 5, 6, 32'h66));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          7, 1, 6, 7, 32'h77));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,          7, 0, 6, 7, 32'h77));

    do_reset();
    check("reset_writeFlag", {31'd0, writeFlag}, 32'd0);
    check("reset_robId", {28'd0, robId}, 32'd0);
    check("reset_writeAddr", {27'd0, writeAddr}, 32'd0);
    check("reset_writeValue", writeValue, 32'd0);
    check("reset_clearOut", {31'd0, clearOut}, 32'd0);
    check("reset_full", {31'd0, full}, 32'd0);
    check("reset_allocId", {28'd0, allocId}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      idle_inputs();
      readyIn = vecs[i].rdy;
      if (vecs[i].alloc) alloc_in(vecs[i].rd, vecs[i].has_rd, 1'b0);
      if (vecs[i].cdb) cdb_in(vecs[i].cid, vecs[i].cval, 1'b0);
      query1Id = vecs[i].qid;
      query2Id = vecs[i].qid;
      #1;
      check($sformatf("v%0d_allocId", i), {28'd0, allocId}, {28'd0, vecs[i].e_aid});
      check($sformatf("v%0d_full", i), {31'd0, full}, 32'd0);
      if (vecs[i].q_chk) begin
        check($sformatf("v%0d_q1Ready", i), {31'd0, query1Ready}, {31'd0, vecs[i].q_rdy});
        check($sformatf("v%0d_q2Ready", i), {31'd0, query2Ready}, {31'd0, vecs[i].q_rdy});
        if (vecs[i].q_rdy) begin
          check($sformatf("v%0d_q1Value", i), query1Value, vecs[i].q_val);
          check($sformatf("v%0d_q2Value", i), query2Value, vecs[i].q_val);
        end
      end
      step();
      check($sformatf("v%0d_writeFlag", i), {31'd0, writeFlag}, {31'd0, vecs[i].e_wf});
      check($sformatf("v%0d_robId", i), {28'd0, robId}, {28'd0, vecs[i].e_rid});
      check($sformatf("v%0d_writeAddr", i), {27'd0, writeAddr}, {27'd0, vecs[i].e_addr});
      check($sformatf("v%0d_writeValue", i), writeValue, vecs[i].e_val);
      check($sformatf("v%0d_clearOut", i), {31'd0, clearOut}, 32'd0);
    end

    // Fill all 16 entries, reject a 17th, then retire id0 while alloc is held.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill%0d_allocId", i), {28'd0, allocId}, i);
      check($sformatf("fill%0d_full", i), {31'd0, full}, 32'd0);
      alloc_in(5'(i + 1), 1'b1, 1'b0);
      step();
    end
    check("full_after16", {31'd0, full}, 32'd1);
    check("tail_wrapped", {28'd0, allocId}, 32'd0);
    step();
    check("alloc17_ignored_tail", {28'd0, allocId}, 32'd0);
    check("alloc17_ignored_full", {31'd0, full}, 32'd1);
    cdb_in(4'd0, 32'h55, 1'b0);
    step();
    cdbFlag = 1'b0;
    check("full_cdb_cycle", {31'd0, full}, 32'd1);
    check("full_cdb_wf", {31'd0, writeFlag}, 32'd0);
    step();
    check("full_commit_wf", {31'd0, writeFlag}, 32'd1);
    check("full_commit_rid", {28'd0, robId}, 32'd0);
    check("full_commit_val", writeValue, 32'h55);
    check("full_commit_alloc_blocked", {28'd0, allocId}, 32'd0);
    check("full_commit_freed", {31'd0, full}, 32'd0);
    step();
    check("refill_allocId", {28'd0, allocId}, 32'd1);
    check("refill_full", {31'd0, full}, 32'd1);
    idle_inputs();

    // Mispredicted branch at id1 behind id0, with ids 2..4 pending.
    do_reset();
    alloc_in(5'd1, 1'b1, 1'b0); step();
    alloc_in(5'd0, 1'b0, 1'b1); step();
    alloc_in(5'd2, 1'b1, 1'b0); step();
    alloc_in(5'd3, 1'b1, 1'b0); step();
    alloc_in(5'd4, 1'b1, 1'b0); step();
    idle_inputs();
    cdb_in(4'd1, 32'd0, 1'b1); step();
    cdb_in(4'd0, 32'hA, 1'b0); step();
    idle_inputs();
    check("mp_pre_clear", {31'd0, clearOut}, 32'd0);
    step();
    check("mp_id0_wf", {31'd0, writeFlag}, 32'd1);
    check("mp_id0_rid", {28'd0, robId}, 32'd0);
    check("mp_id0_val", writeValue, 32'hA);
    check("mp_id0_clear", {31'd0, clearOut}, 32'd0);
    step();
    check("mp_clearOut", {31'd0, clearOut}, 32'd1);
    check("mp_flush_wf", {31'd0, writeFlag}, 32'd0);
    check("mp_flush_full", {31'd0, full}, 32'd0);
    check("mp_flush_allocId", {28'd0, allocId}, 32'd0);
    alloc_in(5'd9, 1'b1, 1'b0);
    cdb_in(4'd2, 32'h5, 1'b0);
    step();
    idle_inputs();
    query1Id = 4'd2;
    #1;
    check("mp_clear_pulse_end", {31'd0, clearOut}, 32'd0);
    check("mp_flush_alloc_dropped", {28'd0, allocId}, 32'd0);
    check("mp_entry2_gone", {31'd0, query1Ready}, 32'd0);
    alloc_in(5'd8, 1'b1, 1'b0);
    step();
    idle_inputs();
    check("mp_next_alloc_id0", {28'd0, allocId}, 32'd1);

    // Reset while entries are in flight: empty queue, no clear pulse.
    alloc_in(5'd3, 1'b1, 1'b0); step();
    idle_inputs();
    resetIn = 1'b1;
    step();
    resetIn = 1'b0;
    check("midreset_allocId", {28'd0, allocId}, 32'd0);
    check("midreset_clearOut", {31'd0, clearOut}, 32'd0);
    check("midreset_wf", {31'd0, writeFlag}, 32'd0);
    step();
    check("midreset_no_pulse", {31'd0, clearOut}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
